// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register: captures decoded control and operand fields, supports
// stall (hold) and flush (bubble), and keeps a saturating count of injected bubbles.
module decode_execute_reg #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      ValidD,
  input  logic                      RegWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic                      ALUsrcD,
  input  logic                      BranchD,
  input  logic                      JumpD,
  input  logic                      jalrD,
  input  logic                      luiD,
  input  logic [2:0]                R_sizeD,
  input  logic [2:0]                DMem_sizeD,
  input  logic                      load_extend_sD,
  input  logic [3:0]                ALUControlD,
  input  logic [DATA_WIDTH-1:0]     RD1D,
  input  logic [DATA_WIDTH-1:0]     RD2D,
  input  logic [DATA_WIDTH-1:0]     PCD,
  input  logic [DATA_WIDTH-1:0]     PCPlus4D,
  input  logic [DATA_WIDTH-1:0]     ImmExtD,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  output logic                      ValidE,
  output logic                      RegWriteE,
  output logic [1:0]                ResultSrcE,
  output logic                      ALUsrcE,
  output logic                      BranchE,
  output logic                      JumpE,
  output logic                      jalrE,
  output logic                      luiE,
  output logic [2:0]                R_sizeE,
  output logic [2:0]                DMem_sizeE,
  output logic                      load_extend_sE,
  output logic [3:0]                ALUControlE,
  output logic [DATA_WIDTH-1:0]     RD1E,
  output logic [DATA_WIDTH-1:0]     RD2E,
  output logic [DATA_WIDTH-1:0]     PCE,
  output logic [DATA_WIDTH-1:0]     PCPlus4E,
  output logic [DATA_WIDTH-1:0]     ImmExtE,
  output logic [REG_ADDR_WIDTH-1:0] Rs1E,
  output logic [REG_ADDR_WIDTH-1:0] Rs2E,
  output logic [REG_ADDR_WIDTH-1:0] RdE,
  output logic [CNT_WIDTH-1:0]      bubble_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic                      valid;
    logic                      reg_write;
    logic [1:0]                result_src;
    logic                      alu_src;
    logic                      branch;
    logic                      jump;
    logic                      jalr;
    logic                      lui;
    logic [2:0]                r_size;
    logic [2:0]                dmem_size;
    logic                      load_extend_s;
    logic [3:0]                alu_control;
    logic [DATA_WIDTH-1:0]     rd1;
    logic [DATA_WIDTH-1:0]     rd2;
    logic [DATA_WIDTH-1:0]     pc;
    logic [DATA_WIDTH-1:0]     pc_plus4;
    logic [DATA_WIDTH-1:0]     imm_ext;
    logic [REG_ADDR_WIDTH-1:0] rs1;
    logic [REG_ADDR_WIDTH-1:0] rs2;
    logic [REG_ADDR_WIDTH-1:0] rd;
  } idex_t;

  idex_t                r_e;
  idex_t                w_d;
  logic [CNT_WIDTH-1:0] r_bubble_count;

  // Gather the decode-side fields into one stage word.
  always_comb begin
    w_d               = '0;
    w_d.valid         = ValidD;
    w_d.reg_write     = RegWriteD;
    w_d.result_src    = ResultSrcD;
    w_d.alu_src       = ALUsrcD;
    w_d.branch        = BranchD;
    w_d.jump          = JumpD;
    w_d.jalr          = jalrD;
    w_d.lui           = luiD;
    w_d.r_size        = R_sizeD;
    w_d.dmem_size     = DMem_sizeD;
    w_d.load_extend_s = load_extend_sD;
    w_d.alu_control   = ALUControlD;
    w_d.rd1           = RD1D;
    w_d.rd2           = RD2D;
    w_d.pc            = PCD;
    w_d.pc_plus4      = PCPlus4D;
    w_d.imm_ext       = ImmExtD;
    w_d.rs1           = Rs1D;
    w_d.rs2           = Rs2D;
    w_d.rd            = RdD;
  end

  // Stage register with priority reset > flush > stall > load; flush counts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e            <= '0;
      r_bubble_count <= '0;
    end else if (flush) begin
      r_e <= '0;
      if (r_bubble_count != CNT_MAX) begin
        r_bubble_count <= r_bubble_count + CNT_WIDTH'(1);
      end
    end else if (!stall) begin
      r_e <= w_d;
    end
  end

  assign ValidE         = r_e.valid;
  assign RegWriteE      = r_e.reg_write;
  assign ResultSrcE     = r_e.result_src;
  assign ALUsrcE        = r_e.alu_src;
  assign BranchE        = r_e.branch;
  assign JumpE          = r_e.jump;
  assign jalrE          = r_e.jalr;
  assign luiE           = r_e.lui;
  assign R_sizeE        = r_e.r_size;
  assign DMem_sizeE     = r_e.dmem_size;
  assign load_extend_sE = r_e.load_extend_s;
  assign ALUControlE    = r_e.alu_control;
  assign RD1E           = r_e.rd1;
  assign RD2E           = r_e.rd2;
  assign PCE            = r_e.pc;
  assign PCPlus4E       = r_e.pc_plus4;
  assign ImmExtE        = r_e.imm_ext;
  assign Rs1E           = r_e.rs1;
  assign Rs2E           = r_e.rs2;
  assign RdE            = r_e.rd;
  assign bubble_count   = r_bubble_count;

endmodule

// File: tb/tb_decode_execute_reg.sv
// Scoreboard bench for decode_execute_reg: a driver pushes reference-model
// predictions per clock edge, a monitor pops and compares them after the edge.
module tb_decode_execute_reg;

  localparam int VW = 195;

  logic clk = 1'b0;
  logic rst = 1'b1, stall = 1'b0, flush = 1'b0;
  logic ValidD = 1'b0, RegWriteD = 1'b0, ALUsrcD = 1'b0, BranchD = 1'b0;
  logic JumpD = 1'b0, jalrD = 1'b0, luiD = 1'b0, load_extend_sD = 1'b0;
  logic [1:0] ResultSrcD = '0;
  logic [2:0] R_sizeD = '0, DMem_sizeD = '0;
  logic [3:0] ALUControlD = '0;
  logic [31:0] RD1D = '0, RD2D = '0, PCD = '0, PCPlus4D = '0, ImmExtD = '0;
  logic [4:0] Rs1D = '0, Rs2D = '0, RdD = '0;

  logic ValidE, RegWriteE, ALUsrcE, BranchE, JumpE, jalrE, luiE, load_extend_sE;
  logic [1:0] ResultSrcE;
  logic [2:0] R_sizeE, DMem_sizeE;
  logic [3:0] ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic [15:0] bubble_count;

  // Second instance only observes the narrow saturating counter.
  logic ValidE2, RegWriteE2, ALUsrcE2, BranchE2, JumpE2, jalrE2, luiE2, load_extend_sE2;
  logic [1:0] ResultSrcE2;
  logic [2:0] R_sizeE2, DMem_sizeE2;
  logic [3:0] ALUControlE2;
  logic [31:0] RD1E2, RD2E2, PCE2, PCPlus4E2, ImmExtE2;
  logic [4:0] Rs1E2, Rs2E2, RdE2;
  logic [1:0] bubble_count2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [VW-1:0] e;
    int            cnt;
    int            cnt2;
  } exp_t;
  exp_t sb_q[$];

  logic [VW-1:0] m_e = '0;
  int m_cnt = 0;
  int m_cnt2 = 0;

  always #5 clk = ~clk;

  decode_execute_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .ALUsrcD(ALUsrcD),
    .BranchD(BranchD), .JumpD(JumpD), .jalrD(jalrD), .luiD(luiD), .R_sizeD(R_sizeD),
    .DMem_sizeD(DMem_sizeD), .load_extend_sD(load_extend_sD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .ALUsrcE(ALUsrcE),
    .BranchE(BranchE), .JumpE(JumpE), .jalrE(jalrE), .luiE(luiE), .R_sizeE(R_sizeE),
    .DMem_sizeE(DMem_sizeE), .load_extend_sE(load_extend_sE), .ALUControlE(ALUControlE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .bubble_count(bubble_count)
  );

  decode_execute_reg #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ValidD(ValidD), .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .ALUsrcD(ALUsrcD),
    .BranchD(BranchD), .JumpD(JumpD), .jalrD(jalrD), .luiD(luiD), .R_sizeD(R_sizeD),
    .DMem_sizeD(DMem_sizeD), .load_extend_sD(load_extend_sD), .ALUControlD(ALUControlD),
    .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .ValidE(ValidE2), .RegWriteE(RegWriteE2), .ResultSrcE(ResultSrcE2), .ALUsrcE(ALUsrcE2),
    .BranchE(BranchE2), .JumpE(JumpE2), .jalrE(jalrE2), .luiE(luiE2), .R_sizeE(R_sizeE2),
    .DMem_sizeE(DMem_sizeE2), .load_extend_sE(load_extend_sE2), .ALUControlE(ALUControlE2),
    .RD1E(RD1E2), .RD2E(RD2E2), .PCE(PCE2), .PCPlus4E(PCPlus4E2), .ImmExtE(ImmExtE2),
    .Rs1E(Rs1E2), .Rs2E(Rs2E2), .RdE(RdE2), .bubble_count(bubble_count2)
  );

  function automatic logic [VW-1:0] pack_d();
    return {ValidD, RegWriteD, ResultSrcD, ALUsrcD, BranchD, JumpD, jalrD, luiD,
            R_sizeD, DMem_sizeD, load_extend_sD, ALUControlD,
            RD1D, RD2D, PCD, PCPlus4D, ImmExtD, Rs1D, Rs2D, RdD};
  endfunction

  function automatic logic [VW-1:0] pack_e();
    return {ValidE, RegWriteE, ResultSrcE, ALUsrcE, BranchE, JumpE, jalrE, luiE,
            R_sizeE, DMem_sizeE, load_extend_sE, ALUControlE,
            RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE};
  endfunction

  task automatic rand_d();
    ValidD = 1'($urandom_range(0, 1));     RegWriteD = 1'($urandom_range(0, 1));
    ResultSrcD = 2'($urandom_range(0, 3)); ALUsrcD = 1'($urandom_range(0, 1));
    BranchD = 1'($urandom_range(0, 1));    JumpD = 1'($urandom_range(0, 1));
    jalrD = 1'($urandom_range(0, 1));      luiD = 1'($urandom_range(0, 1));
    R_sizeD = 3'($urandom_range(0, 7));    DMem_sizeD = 3'($urandom_range(0, 7));
    load_extend_sD = 1'($urandom_range(0, 1)); ALUControlD = 4'($urandom_range(0, 15));
    RD1D = $urandom; RD2D = $urandom; PCD = $urandom; PCPlus4D = PCD + 32'd4;
    ImmExtD = $urandom;
    Rs1D = 5'($urandom_range(0, 31)); Rs2D = 5'($urandom_range(0, 31));
    RdD = 5'($urandom_range(0, 31));
  endtask

  // One clock: apply controls, predict the post-edge state, queue the prediction.
  task automatic step(input logic r, input logic s, input logic f);
    exp_t it;
    rst = r; stall = s; flush = f;
    @(posedge clk);
    if (r) begin
      m_e = '0; m_cnt = 0; m_cnt2 = 0;
    end else if (f) begin
      m_e = '0;
      m_cnt  = (m_cnt  < 65535) ? m_cnt + 1  : m_cnt;
      m_cnt2 = (m_cnt2 < 3)     ? m_cnt2 + 1 : m_cnt2;
    end else if (!s) begin
      m_e = pack_d();
    end
    it.e = m_e; it.cnt = m_cnt; it.cnt2 = m_cnt2;
    sb_q.push_back(it);
    @(negedge clk);
  endtask

  // Monitor: outputs are presented every cycle, compare one prediction per edge.
  initial begin
    exp_t it;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        it = sb_q.pop_front();
        checks++;
        if (pack_e() !== it.e) begin
          errors++;
          $display("FAIL e_outputs t=%0t got=%h exp=%h", $time, pack_e(), it.e);
        end
        checks++;
        if (int'(bubble_count) != it.cnt || $isunknown(bubble_count)) begin
          errors++;
          $display("FAIL bubble_count t=%0t got=%0d exp=%0d", $time, bubble_count, it.cnt);
        end
        checks++;
        if (int'(bubble_count2) != it.cnt2 || $isunknown(bubble_count2)) begin
          errors++;
          $display("FAIL bubble_count_w2 t=%0t got=%0d exp=%0d", $time, bubble_count2, it.cnt2);
        end
      end
    end
  end

  initial begin
    logic r, s, f;
    // Reset with random D inputs, then a first real instruction.
    rand_d(); step(1, 0, 0);
    rand_d(); step(1, 0, 0);
    rand_d(); RdD = 5'd5; RegWriteD = 1'b1; RD1D = 32'h1234; ValidD = 1'b1;
    step(0, 0, 0);
    // Stall holds the earlier instruction while D changes.
    rand_d(); PCD = 32'h100; step(0, 0, 0);
    rand_d(); PCD = 32'h104;
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(0, 0, 0);
    // Flush injects a bubble, then normal load resumes.
    rand_d(); PCD = 32'h200; BranchD = 1'b1; ValidD = 1'b1;
    step(0, 0, 1);
    step(0, 0, 0);
    // Flush wins over simultaneous stall.
    rand_d(); RegWriteD = 1'b1; ValidD = 1'b1;
    step(0, 1, 1);
    // Flush then stall: bubble held and not counted again.
    rand_d(); step(0, 1, 0);
    // Saturation of the narrow counter: 1,2,3,3,3.
    step(1, 0, 0);
    for (int i = 0; i < 5; i++) begin rand_d(); step(0, 0, 1); end
    // Reset during a stall with count=2, then load resumes.
    step(1, 0, 0);
    rand_d(); step(0, 0, 1);
    rand_d(); step(0, 0, 1);
    rand_d(); step(0, 1, 0);
    rand_d(); step(1, 1, 0);
    rand_d(); step(0, 0, 0);
    rand_d(); step(0, 0, 0);
    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      rand_d();
      r = ($urandom_range(0, 39) == 0);
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 4) == 0);
      step(r, s, f);
    end
    rst = 1'b0; stall = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
